// File: rtl/bf_iteration_controller_pkg.sv
// Shared types for the Bellman-Ford iteration controller and its bench.
package bf_iteration_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_AGU_RST = 3'd1,
    ST_INIT    = 3'd2,
    ST_PRIME   = 3'd3,
    ST_RUN     = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/bf_phase_counter.sv
// Column phase counter: counts 0..PHASE_CYCLES-1 while enabled and raises the
// pre-rollover / rollover strobes, which are held low whenever it is disabled.
module bf_phase_counter #(
  parameter int PHASE_CYCLES = 4,
  localparam int PW = $clog2(PHASE_CYCLES)
) (
  input  logic clk,
  input  logic rst_global_n,
  input  logic en,
  input  logic clr,
  output logic pre_rollover,
  output logic rollover
);

  localparam logic [PW-1:0] LAST = PW'(PHASE_CYCLES - 1);
  localparam logic [PW-1:0] PRE  = PW'(PHASE_CYCLES - 2);

  logic [PW-1:0] phase_cnt;

  always_ff @(posedge clk) begin
    if (!rst_global_n || clr) begin
      phase_cnt <= '0;
    end else if (en) begin
      phase_cnt <= (phase_cnt == LAST) ? '0 : phase_cnt + PW'(1);
    end
  end

  assign pre_rollover = en && (phase_cnt == PRE);
  assign rollover     = en && (phase_cnt == LAST);

endmodule

// File: rtl/bf_iteration_controller.sv
// Sequences one Bellman-Ford solve: AGU reset, distance-table init sweep, read
// prefetch, column phases, iteration counting, convergence exit and negative-cycle check.
module bf_iteration_controller
  import bf_iteration_controller_pkg::*;
#(
  parameter int NUM_COLUMNS  = 16,
  parameter int PHASE_CYCLES = 4,
  parameter int MAX_ITER     = 15,
  parameter int NEG_CHECK    = 1,
  localparam int ITER_W = $clog2(MAX_ITER + 2),
  localparam int COL_W  = $clog2(NUM_COLUMNS)
) (
  input  logic              clk,
  input  logic              rst_global_n,
  // Host handshake: start is a request honoured only in IDLE; done is a
  // single-cycle completion pulse, busy is high from acceptance until back in IDLE.
  input  logic              start,
  input  logic              abort,
  input  logic              relax_update,
  output logic              agu_rst,
  output logic              read_enable_cu,
  output logic              write_enable_cu,
  output logic              pre_rollover_phase_counter,
  output logic              rollover_phase_counter,
  output logic              init_we,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic              neg_cycle,
  output logic [ITER_W-1:0] iter_count,
  output logic [COL_W-1:0]  col_index,
  output state_t            dbg_state
);

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(NUM_COLUMNS - 1);
  localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

  state_t            state, state_nxt;
  logic              change_flag, check_pass;
  logic              pc_en, pc_clr, roll, pre_roll;
  logic              iter_end, change_now, finish, enter_check;
  logic [ITER_W-1:0] iter_inc;
  logic [COL_W-1:0]  col_wrap;

  bf_phase_counter #(.PHASE_CYCLES(PHASE_CYCLES)) u_phase (
    .clk          (clk),
    .rst_global_n (rst_global_n),
    .en           (pc_en),
    .clr          (pc_clr),
    .pre_rollover (pre_roll),
    .rollover     (roll)
  );

  assign pc_clr      = (state != ST_RUN);
  assign col_wrap    = (col_index == COL_LAST) ? '0 : col_index + COL_W'(1);
  assign iter_inc    = iter_count + ITER_W'(1);
  // The cycle that closes an iteration still counts its own relax_update.
  assign change_now  = change_flag | relax_update;
  assign enter_check = !check_pass && change_now && (iter_inc == ITER_MAX) && (NEG_CHECK != 0);
  assign finish      = check_pass || !change_now || ((iter_inc == ITER_MAX) && (NEG_CHECK == 0));

  always_comb begin
    state_nxt       = state;
    agu_rst         = 1'b0;
    read_enable_cu  = 1'b0;
    write_enable_cu = 1'b0;
    init_we         = 1'b0;
    pc_en           = 1'b0;
    iter_end        = 1'b0;
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_AGU_RST;
      ST_AGU_RST: begin
        agu_rst   = 1'b1;
        state_nxt = ST_INIT;
      end
      ST_INIT: begin
        write_enable_cu = 1'b1;
        init_we         = 1'b1;
        if (col_index == COL_LAST) state_nxt = ST_PRIME;
      end
      ST_PRIME: begin
        read_enable_cu = 1'b1;
        state_nxt      = ST_RUN;
      end
      ST_RUN: begin
        pc_en          = 1'b1;
        read_enable_cu = roll;
        if (roll && (col_index == COL_LAST)) begin
          iter_end = 1'b1;
          if (finish) state_nxt = ST_DONE;
        end
      end
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
    // Abort overrides everything, including an iteration end in the same cycle.
    if (abort && (state != ST_IDLE)) begin
      state_nxt       = ST_IDLE;
      agu_rst         = 1'b1;
      read_enable_cu  = 1'b0;
      write_enable_cu = 1'b0;
      init_we         = 1'b0;
      pc_en           = 1'b0;
      iter_end        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_global_n) begin
      state       <= ST_IDLE;
      col_index   <= '0;
      iter_count  <= '0;
      change_flag <= 1'b0;
      check_pass  <= 1'b0;
      converged   <= 1'b0;
      neg_cycle   <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && start) begin
        col_index   <= '0;
        iter_count  <= '0;
        change_flag <= 1'b0;
        check_pass  <= 1'b0;
        converged   <= 1'b0;
        neg_cycle   <= 1'b0;
      end
      if (write_enable_cu || (pc_en && roll)) col_index <= col_wrap;
      if (pc_en && relax_update) change_flag <= 1'b1;
      if (iter_end) begin
        iter_count  <= iter_inc;
        change_flag <= 1'b0;
        if (check_pass) begin
          neg_cycle <= change_now;
          converged <= !change_now;
        end else if (!change_now) begin
          converged <= 1'b1;
        end else if (enter_check) begin
          check_pass <= 1'b1;
        end
      end
    end
  end

  assign pre_rollover_phase_counter = pre_roll;
  assign rollover_phase_counter     = roll;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_bf_iteration_controller.sv
// Directed bench for bf_iteration_controller: table of full solves plus
// hand-written abort, start-while-busy and mid-run reset sequences.
module tb_bf_iteration_controller;
  import bf_iteration_controller_pkg::*;

  localparam int RUN_T0  = 18;   // AGU_RST at t=0, INIT t=1..16, PRIME t=17
  localparam int PASS_T  = 64;
  localparam int BUDGET  = 3000;

  logic       clk = 1'b0;
  logic       rst_global_n, start, abort, relax_update;
  logic       agu_rst, read_enable_cu, write_enable_cu, pre_rollover_phase_counter;
  logic       rollover_phase_counter, init_we, busy, done, converged, neg_cycle;
  logic [4:0] iter_count;
  logic [3:0] col_index;
  state_t     dbg_state;

  bf_iteration_controller dut (
    .clk                        (clk),
    .rst_global_n               (rst_global_n),
    .start                      (start),
    .abort                      (abort),
    .relax_update               (relax_update),
    .agu_rst                    (agu_rst),
    .read_enable_cu             (read_enable_cu),
    .write_enable_cu            (write_enable_cu),
    .pre_rollover_phase_counter (pre_rollover_phase_counter),
    .rollover_phase_counter     (rollover_phase_counter),
    .init_we                    (init_we),
    .busy                       (busy),
    .done                       (done),
    .converged                  (converged),
    .neg_cycle                  (neg_cycle),
    .iter_count                 (iter_count),
    .col_index                  (col_index),
    .dbg_state                  (dbg_state)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] mask;     // bit p set: one relax_update in pass p
    int          pos;      // RUN-cycle offset within the pass for that update
    int          exp_t;
    int          exp_iter;
    int          exp_conv;
    int          exp_neg;
  } vec_t;

  int r_done_t, r_roll, r_pre, r_rd, r_we, r_init, r_agu, r_strobe_err, r_col_err;

  function automatic logic relax_for(input int t, input logic [31:0] mask, input int pos);
    int r;
    r = t - RUN_T0;
    if (r < 0) return 1'b0;
    return mask[(r / PASS_T) + 1] && ((r % PASS_T) == pos);
  endfunction

  task automatic run_solve(input logic [31:0] mask, input int pos, input int restart_t);
    int t;
    int r;
    r_done_t = -1; r_roll = 0; r_pre = 0; r_rd = 0; r_we = 0; r_init = 0; r_agu = 0;
    r_strobe_err = 0; r_col_err = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t = 0;
    while (t < BUDGET) begin
      r_roll += int'(rollover_phase_counter);
      r_pre  += int'(pre_rollover_phase_counter);
      r_rd   += int'(read_enable_cu);
      r_we   += int'(write_enable_cu);
      r_init += int'(init_we);
      r_agu  += int'(agu_rst);
      if (done) begin
        r_done_t = t;
        break;
      end
      if (t >= RUN_T0) begin
        r = t - RUN_T0;
        if (rollover_phase_counter != ((r % 4) == 3)) r_strobe_err++;
        if (pre_rollover_phase_counter != ((r % 4) == 2)) r_strobe_err++;
        if (int'(col_index) != ((r / 4) % 16)) r_col_err++;
      end
      relax_update = relax_for(t, mask, pos);
      start = (t == restart_t);
      @(posedge clk); #1;
      t++;
    end
    relax_update = 1'b0;
    start = 1'b0;
  endtask

  task automatic check_solve(input string tag, input vec_t v);
    int passes;
    passes = v.exp_iter;
    chk({tag, " done_t"},     r_done_t, v.exp_t);
    chk({tag, " iter_count"}, int'(iter_count), v.exp_iter);
    chk({tag, " converged"},  int'(converged), v.exp_conv);
    chk({tag, " neg_cycle"},  int'(neg_cycle), v.exp_neg);
    chk({tag, " n_rollover"}, r_roll, 16 * passes);
    chk({tag, " n_pre_roll"}, r_pre, 16 * passes);
    chk({tag, " n_read_en"},  r_rd, 1 + 16 * passes);
    chk({tag, " n_write_en"}, r_we, 16);
    chk({tag, " n_init_we"},  r_init, 16);
    chk({tag, " n_agu_rst"},  r_agu, 1);
    chk({tag, " strobe_err"}, r_strobe_err, 0);
    chk({tag, " col_err"},    r_col_err, 0);
    @(posedge clk); #1;
    chk({tag, " done_pulse_len"}, int'(done), 0);
    chk({tag, " busy_after"},     int'(busy), 0);
    chk({tag, " conv_held"},      int'(converged), v.exp_conv);
  endtask

  vec_t vecs[4];

  initial begin
    int t;
    int n_done;
    vecs[0] = '{mask: 32'h0000_0000, pos: 0,  exp_t: 82,   exp_iter: 1,  exp_conv: 1, exp_neg: 0};
    vecs[1] = '{mask: 32'h0000_000E, pos: 10, exp_t: 274,  exp_iter: 4,  exp_conv: 1, exp_neg: 0};
    vecs[2] = '{mask: 32'hFFFF_FFFE, pos: 10, exp_t: 1042, exp_iter: 16, exp_conv: 0, exp_neg: 1};
    vecs[3] = '{mask: 32'h0000_0002, pos: 63, exp_t: 146,  exp_iter: 2,  exp_conv: 1, exp_neg: 0};

    // Clock/reset
    rst_global_n = 1'b0; start = 1'b0; abort = 1'b0; relax_update = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", int'({agu_rst, read_enable_cu, write_enable_cu, pre_rollover_phase_counter,
        rollover_phase_counter, init_we, busy, done, converged, neg_cycle, iter_count, col_index}), 0);
    chk("reset state", int'(dbg_state), int'(ST_IDLE));
    rst_global_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      run_solve(vecs[i].mask, vecs[i].pos, -1);
      check_solve($sformatf("vec%0d", i), vecs[i]);
    end

    // start while busy (during RUN) is ignored
    run_solve(32'h0, 0, 40);
    check_solve("restart_busy", vecs[0]);

    // start clears converged/iter_count on the accepting edge
    chk("pre_start converged", int'(converged), 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start clr converged", int'(converged), 0);
    chk("start clr iter", int'(iter_count), 0);
    chk("start agu_rst", int'(agu_rst), 1);
    // advance to RUN column 7, phase 3 (t=49) then abort
    for (t = 0; t < 49; t++) begin
      @(posedge clk); #1;
    end
    chk("abort pre col", int'(col_index), 7);
    abort = 1'b1;
    #1;
    chk("abort agu_rst", int'(agu_rst), 1);
    chk("abort enables", int'({read_enable_cu, write_enable_cu, init_we,
        pre_rollover_phase_counter, rollover_phase_counter}), 0);
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort state", int'(dbg_state), int'(ST_IDLE));
    chk("abort busy", int'(busy), 0);
    chk("abort agu_rst after", int'(agu_rst), 0);
    n_done = 0;
    for (int k = 0; k < 20; k++) begin
      n_done += int'(done) + int'(converged) + int'(neg_cycle);
      @(posedge clk); #1;
    end
    chk("abort no done", n_done, 0);
    run_solve(32'h0, 0, -1);
    check_solve("after_abort", vecs[0]);

    // reset mid-RUN in pass 2 (pass 1 had an update)
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (t = 0; t < 112; t++) begin
      relax_update = relax_for(t, 32'h2, 5);
      @(posedge clk); #1;
    end
    relax_update = 1'b0;
    chk("midrun iter", int'(iter_count), 1);
    chk("midrun col", int'(col_index), 7);
    rst_global_n = 1'b0;
    @(posedge clk); #1;
    chk("midrun reset outputs", int'({agu_rst, read_enable_cu, write_enable_cu, pre_rollover_phase_counter,
        rollover_phase_counter, init_we, busy, done, converged, neg_cycle, iter_count, col_index}), 0);
    chk("midrun reset state", int'(dbg_state), int'(ST_IDLE));
    rst_global_n = 1'b1;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
